// File: rtl/rx_phase_sync_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | rx_phase_sync_ctrl                                                         |
// | Resolves QPSK phase ambiguity by stepping iq_rot, frames on a sync word,   |
// | and emits payload bytes on a valid/ready stream with flywheel lock.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rx_phase_sync_ctrl #(
  parameter logic [63:0] SYNC_WORD      = 64'h1ACFFC1D,
  parameter int          SYNC_LEN       = 16,
  parameter int          SEARCH_TIMEOUT = 4096,
  parameter int          RST_CYCLES     = 64,
  parameter int          FRAME_BYTES    = 64,
  parameter int          MISS_MAX       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] sym_data,
  output logic [1:0] iq_rot,
  output logic       rx_rst,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       locked,
  output logic       search_wrap,
  output logic       overflow
);

  localparam int SRW     = 2 * SYNC_LEN;
  localparam int CNT_MAX = (SEARCH_TIMEOUT > SYNC_LEN) ? SEARCH_TIMEOUT : SYNC_LEN;
  localparam int SCW     = $clog2(CNT_MAX + 1);
  localparam int RCW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int BCW     = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int MCW     = $clog2(MISS_MAX + 1);

  localparam logic [SRW-1:0] c_sync_pat   = SYNC_WORD[SRW-1:0];
  localparam logic [SCW-1:0] c_sync_len   = SCW'(SYNC_LEN);
  localparam logic [SCW-1:0] c_timeout    = SCW'(SEARCH_TIMEOUT);
  localparam logic [RCW-1:0] c_rst_last   = RCW'(RST_CYCLES - 1);
  localparam logic [BCW-1:0] c_frame_last = BCW'(FRAME_BYTES - 1);
  localparam logic [MCW-1:0] c_miss_max   = MCW'(MISS_MAX);

  typedef enum logic [1:0] {
    ST_RESTART = 2'd0,
    ST_HUNT    = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     iq_rot_q, iq_rot_d;
  logic           rx_rst_q, rx_rst_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SCW-1:0] sym_cnt_q, sym_cnt_d;
  logic [MCW-1:0] miss_q, miss_d;
  logic [SRW-1:0] sr_q, sr_d;
  logic [5:0]     pack_q, pack_d;
  logic [1:0]     sub_q, sub_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]     out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           out_sof_q, out_sof_d;
  logic           locked_q, locked_d;
  logic           wrap_q, wrap_d;
  logic           ovf_q, ovf_d;

  logic           w_acc;
  logic [SRW-1:0] w_sr_shift;
  logic           w_match;
  logic [SCW-1:0] w_cnt_inc;
  logic [MCW-1:0] w_miss_inc;
  logic           w_new_byte;
  logic           w_byte_sof;

  // Symbols arriving while the RX path is being restarted are stale.
  assign w_acc      = sym_valid && (state_q != ST_RESTART) && !rx_rst_q;
  assign w_sr_shift = {sr_q[SRW-3:0], sym_data};
  assign w_match    = (w_sr_shift == c_sync_pat);
  assign w_cnt_inc  = sym_cnt_q + SCW'(1);
  assign w_miss_inc = miss_q + MCW'(1);

  always_comb begin
    state_d     = state_q;
    iq_rot_d    = iq_rot_q;
    rst_cnt_d   = rst_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    miss_d      = miss_q;
    sr_d        = sr_q;
    pack_d      = pack_q;
    sub_d       = sub_q;
    byte_cnt_d  = byte_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    ovf_d       = ovf_q;
    wrap_d      = 1'b0;
    w_new_byte  = 1'b0;
    w_byte_sof  = 1'b0;

    if (w_acc) sr_d = w_sr_shift;

    case (state_q)
      ST_RESTART: begin
        sr_d       = '0;
        sym_cnt_d  = '0;
        miss_d     = '0;
        sub_d      = '0;
        byte_cnt_d = '0;
        if (rst_cnt_q == c_rst_last) begin
          rst_cnt_d = '0;
          state_d   = ST_HUNT;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      ST_HUNT: begin
        if (w_acc) begin
          sym_cnt_d = w_cnt_inc;
          // A match takes priority over a coincident timeout.
          if (w_match && (w_cnt_inc >= c_sync_len)) begin
            state_d    = ST_LOCKED;
            sym_cnt_d  = '0;
            miss_d     = '0;
            sub_d      = '0;
            byte_cnt_d = '0;
          end else if (w_cnt_inc == c_timeout) begin
            iq_rot_d = iq_rot_q + 2'd1;
            wrap_d   = (iq_rot_q == 2'd3);
            state_d  = ST_RESTART;
          end
        end
      end
      ST_LOCKED: begin
        if (w_acc) begin
          pack_d = {pack_q[3:0], sym_data};
          sub_d  = sub_q + 2'd1;
          if (sub_q == 2'd3) begin
            w_new_byte = 1'b1;
            w_byte_sof = (byte_cnt_q == '0);
            if (byte_cnt_q == c_frame_last) begin
              byte_cnt_d = '0;
              sym_cnt_d  = '0;
              state_d    = ST_CHECK;
            end else begin
              byte_cnt_d = byte_cnt_q + BCW'(1);
            end
          end
        end
      end
      ST_CHECK: begin
        if (w_acc) begin
          sym_cnt_d = w_cnt_inc;
          if (w_cnt_inc == c_sync_len) begin
            sym_cnt_d = '0;
            sub_d     = '0;
            if (w_match) begin
              miss_d  = '0;
              state_d = ST_LOCKED;
            end else if (w_miss_inc >= c_miss_max) begin
              miss_d  = '0;
              sr_d    = '0;
              state_d = ST_HUNT;
            end else begin
              miss_d  = w_miss_inc;
              state_d = ST_LOCKED;
            end
          end
        end
      end
      default: state_d = ST_RESTART;
    endcase

    // Output holding register: a byte that cannot drain is replaced, never stalled.
    if (w_new_byte) begin
      out_data_d  = {pack_q, sym_data};
      out_sof_d   = w_byte_sof;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) ovf_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    rx_rst_d = (state_d == ST_RESTART);
    locked_d = (state_d == ST_LOCKED) || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESTART;
      iq_rot_q    <= 2'd0;
      rx_rst_q    <= 1'b1;
      rst_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      miss_q      <= '0;
      sr_q        <= '0;
      pack_q      <= '0;
      sub_q       <= '0;
      byte_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      locked_q    <= 1'b0;
      wrap_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      iq_rot_q    <= iq_rot_d;
      rx_rst_q    <= rx_rst_d;
      rst_cnt_q   <= rst_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      miss_q      <= miss_d;
      sr_q        <= sr_d;
      pack_q      <= pack_d;
      sub_q       <= sub_d;
      byte_cnt_q  <= byte_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      locked_q    <= locked_d;
      wrap_q      <= wrap_d;
      ovf_q       <= ovf_d;
    end
  end

  assign iq_rot      = iq_rot_q;
  assign rx_rst      = rx_rst_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sof     = out_sof_q;
  assign locked      = locked_q;
  assign search_wrap = wrap_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_phase_sync_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_rx_phase_sync_ctrl                                                      |
// | Directed self-checking bench for rx_phase_sync_ctrl.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_rx_phase_sync_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_data = 2'd0;
  logic       out_ready = 1'b1;
  logic [1:0] iq_rot;
  logic       rx_rst;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sof;
  logic       locked;
  logic       search_wrap;
  logic       overflow;

  int         n_cmp = 0;
  int         n_err = 0;
  int         hs_cnt = 0;
  logic [7:0] hs_last = 8'h00;

  rx_phase_sync_ctrl #(
    .SYNC_WORD      (64'h1ACFFC1D),
    .SYNC_LEN       (16),
    .SEARCH_TIMEOUT (256),
    .RST_CYCLES     (64),
    .FRAME_BYTES    (4),
    .MISS_MAX       (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .iq_rot      (iq_rot),
    .rx_rst      (rx_rst),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sof     (out_sof),
    .locked      (locked),
    .search_wrap (search_wrap),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] sync_sym(input int i);
    logic [31:0] w;
    w = 32'h1ACFFC1D;
    return w[31-2*i -: 2];
  endfunction

  // One clock; handshakes seen during the cycle are logged before the edge.
  task automatic tick();
    if (out_valid && out_ready) begin
      hs_cnt++;
      hs_last = out_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] s);
    sym_valid = 1'b1;
    sym_data  = s;
    tick();
  endtask

  task automatic idle(input int n);
    sym_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_sync(input bit corrupt);
    logic [1:0] s;
    for (int i = 0; i < 16; i++) begin
      s = sync_sym(i);
      if (corrupt && i == 15) s = ~s;
      send_sym(s);
    end
  endtask

  task automatic send_pay(input int nbytes, input logic [7:0] b);
    for (int n = 0; n < nbytes; n++)
      for (int k = 0; k < 4; k++) send_sym(b[7-2*k -: 2]);
  endtask

  task automatic do_reset();
    int c;
    rst = 1'b1;
    sym_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    c = 0;
    while (rx_rst && c < 500) begin
      tick();
      c++;
    end
    n_cmp++;
    if (rx_rst !== 1'b0) begin n_err++; $display("FAIL restart_timeout: rx_rst=%b after %0d cycles, want 0", rx_rst, c); end
  endtask

  // Streams zeros, or the sync word only while iq_rot equals target, until lock.
  task automatic run_search(input logic [1:0] target, input int budget,
                            output int restarts, output int wraps, output logic [3:0] rots);
    int   idx;
    int   cyc;
    logic prev;
    restarts = 0; wraps = 0; rots = 4'b0000; idx = 0; cyc = 0; prev = rx_rst;
    while (!locked && cyc < budget) begin
      if (rx_rst) begin
        sym_valid = 1'b0;
        idx = 0;
      end else if (iq_rot == target) begin
        sym_valid = 1'b1;
        sym_data  = sync_sym(idx % 16);
        idx++;
      end else begin
        sym_valid = 1'b1;
        sym_data  = 2'd0;
      end
      tick();
      if (rx_rst && !prev) begin
        restarts++;
        rots[iq_rot] = 1'b1;
      end
      prev = rx_rst;
      if (search_wrap) wraps++;
      cyc++;
    end
  endtask

  task automatic test_reset();
    int c;
    rst = 1'b1;
    sym_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rx_rst !== 1'b1)    begin n_err++; $display("FAIL reset_rx_rst: got %b want 1", rx_rst); end
    n_cmp++; if (iq_rot !== 2'd0)    begin n_err++; $display("FAIL reset_iq_rot: got %0d want 0", iq_rot); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (locked !== 1'b0)    begin n_err++; $display("FAIL reset_locked: got %b want 0", locked); end
    rst = 1'b0;
    c = 0;
    while (rx_rst && c < 200) begin
      c++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (c != 64)            begin n_err++; $display("FAIL reset_rx_rst_len: got %0d cycles want 64", c); end
    n_cmp++; if (iq_rot !== 2'd0)    begin n_err++; $display("FAIL reset_rot_after: got %0d want 0", iq_rot); end
    n_cmp++; if (locked !== 1'b0)    begin n_err++; $display("FAIL reset_locked_after: got %b want 0", locked); end
  endtask

  task automatic test_lock_rot0();
    out_ready = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 15; i++) send_sym(sync_sym(i));
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_early: got %b want 0", locked); end
    send_sym(sync_sym(15));
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_rot0: got %b want 1", locked); end
    for (int b = 0; b < 4; b++) begin
      send_pay(1, 8'h1B);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lock_byte_valid[%0d]: got %b want 1", b, out_valid); end
      n_cmp++; if (out_data !== 8'h1B) begin n_err++; $display("FAIL lock_byte_data[%0d]: got %h want 1b", b, out_data); end
      n_cmp++; if (out_sof !== (b == 0)) begin n_err++; $display("FAIL lock_byte_sof[%0d]: got %b want %b", b, out_sof, (b == 0)); end
    end
    idle(1);
    n_cmp++; if (hs_cnt != 4) begin n_err++; $display("FAIL lock_byte_count: got %0d want 4", hs_cnt); end
  endtask

  task automatic test_flywheel();
    send_sync(1'b0);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL fly_clean: got %b want 1", locked); end
    send_pay(4, 8'hA5);
    for (int m = 1; m <= 2; m++) begin
      send_sync(1'b1);
      n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL fly_miss%0d_locked: got %b want 1", m, locked); end
      hs_cnt = 0;
      send_pay(4, 8'h3C);
      idle(1);
      n_cmp++; if (hs_cnt != 4 || hs_last !== 8'h3C) begin n_err++; $display("FAIL fly_miss%0d_payload: got %0d bytes last %h want 4 bytes last 3c", m, hs_cnt, hs_last); end
    end
    send_sync(1'b1);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL fly_drop: got %b want 0", locked); end
    n_cmp++; if (iq_rot !== 2'd0) begin n_err++; $display("FAIL fly_drop_rot: got %0d want 0", iq_rot); end
    n_cmp++; if (rx_rst !== 1'b0) begin n_err++; $display("FAIL fly_drop_no_restart: got %b want 0", rx_rst); end
    send_sync(1'b0);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL fly_relock: got %b want 1", locked); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_pay(1, 8'h1B);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h1B || out_sof !== 1'b1) begin n_err++; $display("FAIL bp_first: got v=%b d=%h sof=%b want v=1 d=1b sof=1", out_valid, out_data, out_sof); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_no_ovf_yet: got %b want 0", overflow); end
    send_sym(2'd3); send_sym(2'd2); send_sym(2'd1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h1B) begin n_err++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=1b", out_valid, out_data); end
    send_sym(2'd0);
    n_cmp++; if (out_data !== 8'hE4 || out_sof !== 1'b0) begin n_err++; $display("FAIL bp_overwrite: got d=%h sof=%b want d=e4 sof=0", out_data, out_sof); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_ovf_set: got %b want 1", overflow); end
    out_ready = 1'b1;
    hs_cnt = 0;
    send_pay(2, 8'h77);
    idle(2);
    n_cmp++; if (hs_cnt != 3 || hs_last !== 8'h77) begin n_err++; $display("FAIL bp_drain: got %0d bytes last %h want 3 bytes last 77", hs_cnt, hs_last); end
    n_cmp++; if (overflow !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_sticky: got ovf=%b v=%b want ovf=1 v=0", overflow, out_valid); end
  endtask

  task automatic test_phase_search();
    int         r;
    int         w;
    logic [3:0] rots;
    do_reset();
    run_search(2'd2, 3000, r, w, rots);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL search_lock: got %b want 1", locked); end
    n_cmp++; if (iq_rot !== 2'd2) begin n_err++; $display("FAIL search_rot: got %0d want 2", iq_rot); end
    n_cmp++; if (r != 2 || rots !== 4'b0110) begin n_err++; $display("FAIL search_restarts: got %0d rots %b want 2 rots 0110", r, rots); end
    n_cmp++; if (w != 0) begin n_err++; $display("FAIL search_no_wrap: got %0d pulses want 0", w); end
  endtask

  task automatic test_wrap();
    int         r;
    int         cyc;
    logic       prev;
    logic       seen;
    logic [1:0] rot_at;
    do_reset();
    r = 0; cyc = 0; seen = 1'b0; rot_at = 2'd3; prev = rx_rst;
    while (!seen && cyc < 4000) begin
      sym_valid = !rx_rst;
      sym_data  = 2'd0;
      tick();
      if (rx_rst && !prev) r++;
      prev = rx_rst;
      if (search_wrap) begin
        seen   = 1'b1;
        rot_at = iq_rot;
      end
      cyc++;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL wrap_seen: got %b want 1", seen); end
    n_cmp++; if (r != 4) begin n_err++; $display("FAIL wrap_timeouts: got %0d want 4", r); end
    n_cmp++; if (rot_at !== 2'd0) begin n_err++; $display("FAIL wrap_rot: got %0d want 0", rot_at); end
    idle(1);
    n_cmp++; if (search_wrap !== 1'b0) begin n_err++; $display("FAIL wrap_pulse_len: got %b want 0", search_wrap); end
  endtask

  task automatic test_async_rst();
    int         r;
    int         w;
    logic [3:0] rots;
    out_ready = 1'b1;
    run_search(2'd3, 4000, r, w, rots);
    n_cmp++; if (locked !== 1'b1 || iq_rot !== 2'd3) begin n_err++; $display("FAIL arst_pre_lock: got locked=%b rot=%0d want 1/3", locked, iq_rot); end
    out_ready = 1'b0;
    send_pay(2, 8'hC3);
    send_sym(2'd1);
    send_sym(2'd2);
    n_cmp++; if (out_valid !== 1'b1 || overflow !== 1'b1) begin n_err++; $display("FAIL arst_pre_out: got v=%b ovf=%b want 1/1", out_valid, overflow); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (iq_rot !== 2'd0 || rx_rst !== 1'b1 || locked !== 1'b0) begin n_err++; $display("FAIL arst_ctrl: got rot=%0d rx_rst=%b locked=%b want 0/1/0", iq_rot, rx_rst, locked); end
    n_cmp++; if (out_valid !== 1'b0 || out_sof !== 1'b0 || overflow !== 1'b0 || search_wrap !== 1'b0) begin n_err++; $display("FAIL arst_out: got v=%b sof=%b ovf=%b wrap=%b want all 0", out_valid, out_sof, overflow, search_wrap); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    run_search(2'd0, 2000, r, w, rots);
    n_cmp++; if (locked !== 1'b1 || iq_rot !== 2'd0 || r != 0) begin n_err++; $display("FAIL arst_relock: got locked=%b rot=%0d restarts=%0d want 1/0/0", locked, iq_rot, r); end
  endtask

  initial begin
    test_reset();
    test_lock_rot0();
    test_flywheel();
    test_backpressure();
    test_phase_search();
    test_wrap();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
